// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: source tags, access sizes
// and the default outstanding-transaction depth.
package sram_req_arbiter_pkg;
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int OT_DEPTH_DEF = 4;
endpackage

// File: rtl/sram_req_arbiter_ot_tag_fifo.sv
// In-order 1-bit source-tag FIFO: one entry per accepted request, popped on
// each bridge response so data_ok can be routed to the issuing port.
module ot_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tag_in,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_tags;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Self-protecting: overflow/underflow requests are ignored.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= tag_in;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_tags[r_rd_ptr];
  assign full  = (r_count == (PW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one like-SRAM master port between inst and data ports: fixed data
// priority with inst anti-starvation, responses routed by an in-order tag FIFO.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OT_DEPTH   = OT_DEPTH_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_sram_req,
  input  logic                      inst_sram_wr,
  input  logic [1:0]                inst_sram_size,
  input  logic [3:0]                inst_sram_wstrb,
  input  logic [31:0]               inst_sram_addr,
  input  logic [31:0]               inst_sram_wdata,
  output logic                      inst_sram_addr_ok,
  output logic                      inst_sram_data_ok,
  output logic [31:0]               inst_sram_rdata,
  input  logic                      data_sram_req,
  input  logic                      data_sram_wr,
  input  logic [1:0]                data_sram_size,
  input  logic [3:0]                data_sram_wstrb,
  input  logic [31:0]               data_sram_addr,
  input  logic [31:0]               data_sram_wdata,
  output logic                      data_sram_addr_ok,
  output logic                      data_sram_data_ok,
  output logic [31:0]               data_sram_rdata,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [1:0]                mem_size,
  output logic [3:0]                mem_wstrb,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_addr_ok,
  input  logic                      mem_data_ok,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(OT_DEPTH):0] ot_count,
  output logic                      order_err
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          w_sel_inst;
  logic          w_sel_data;
  logic          w_acc;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head;

  assign w_sel_inst = inst_sram_req & (~data_sram_req | (r_starve == SW'(STARVE_MAX)));
  assign w_sel_data = ~w_sel_inst & data_sram_req;
  // No full-bypass: a same-cycle pop does not unmask the request.
  assign mem_req    = (inst_sram_req | data_sram_req) & ~w_full;
  assign w_acc      = mem_req & mem_addr_ok;
  assign w_pop      = mem_data_ok & ~w_empty;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_sel_inst) begin
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end else if (w_sel_data) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end
  end

  assign inst_sram_addr_ok = w_acc & w_sel_inst;
  assign data_sram_addr_ok = w_acc & w_sel_data;

  assign inst_sram_data_ok = w_pop & (w_head == SRC_INST);
  assign data_sram_data_ok = w_pop & (w_head == SRC_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : 32'd0;
  assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : 32'd0;

  ot_tag_fifo #(.DEPTH(OT_DEPTH)) u_tags (
    .clk    (clk),
    .reset  (reset),
    .push   (w_acc),
    .pop    (w_pop),
    .tag_in (w_sel_data ? SRC_DATA : SRC_INST),
    .head   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (ot_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve  <= '0;
      order_err <= 1'b0;
    end else begin
      if (mem_data_ok & w_empty) order_err <= 1'b1;
      if (~inst_sram_req | (w_acc & w_sel_inst))
        r_starve <= '0;
      else if (w_acc & w_sel_data & (r_starve != SW'(STARVE_MAX)))
        r_starve <= r_starve + SW'(1);
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: vector table for single transfers and
// starvation, hand sequences for full, ordering, push/pop and error/reset.
module tb_sram_req_arbiter;
  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  ot_count;
  logic        order_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OT_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ot_count(ot_count), .order_err(order_err)
  );

  typedef struct {
    bit          ireq, dreq, aok, dok;
    logic [31:0] rdata;
    bit          e_mreq, e_iaok, e_daok, e_idok, e_ddok;
    logic [31:0] e_addr, e_irdata, e_drdata;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge; outputs are sampled 1 time unit later.
  task automatic drv(input bit ireq, input bit dreq, input bit aok, input bit dok,
                     input logic [31:0] rd);
    @(negedge clk);
    inst_sram_req = ireq;
    data_sram_req = dreq;
    mem_addr_ok   = aok;
    mem_data_ok   = dok;
    mem_rdata     = rd;
    #1;
  endtask

  task automatic addv(input bit ir, input bit dr, input bit ak, input bit dk, input logic [31:0] rd,
                      input bit mr, input bit ia, input bit da, input bit id, input bit dd,
                      input logic [31:0] ad, input logic [31:0] ird, input logic [31:0] drd,
                      input int cnt);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.aok = ak; v.dok = dk; v.rdata = rd;
    v.e_mreq = mr; v.e_iaok = ia; v.e_daok = da; v.e_idok = id; v.e_ddok = dd;
    v.e_addr = ad; v.e_irdata = ird; v.e_drdata = drd; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hf;
    inst_sram_addr = IA; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'hf;
    data_sram_addr = DA; data_sram_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;

    // ir dr ak dk rdata | mreq iaok daok idok ddok addr irdata drdata cnt
    addv(0,0,0,0,32'h0,          0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0);
    addv(0,1,1,0,32'h0,          1,0,1,0,0, DA,    32'h0, 32'h0, 0);
    addv(0,0,0,0,32'h0,          0,0,0,0,0, 32'h0, 32'h0, 32'h0, 1);
    addv(0,0,0,1,32'hDEADBEEF,   0,0,0,0,1, 32'h0, 32'h0, 32'hDEADBEEF, 1);
    addv(0,0,0,0,32'h0,          0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0);
    addv(1,1,1,0,32'h0,          1,0,1,0,0, DA,    32'h0, 32'h0, 0);
    addv(1,1,1,1,32'h101,        1,0,1,0,1, DA,    32'h0, 32'h101, 1);
    addv(1,1,1,1,32'h102,        1,0,1,0,1, DA,    32'h0, 32'h102, 1);
    addv(1,1,1,1,32'h103,        1,1,0,0,1, IA,    32'h0, 32'h103, 1);
    addv(1,1,1,1,32'h104,        1,0,1,1,0, DA,    32'h104, 32'h0, 1);
    addv(1,1,1,1,32'h105,        1,0,1,0,1, DA,    32'h0, 32'h105, 1);
    addv(1,1,1,1,32'h106,        1,0,1,0,1, DA,    32'h0, 32'h106, 1);
    addv(1,1,1,1,32'h107,        1,1,0,0,1, IA,    32'h0, 32'h107, 1);
    addv(0,0,0,1,32'h108,        0,0,0,1,0, 32'h0, 32'h108, 32'h0, 1);
    addv(0,0,0,0,32'h0,          0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0);

    #3;
    chk("reset ot_count", 32'(ot_count), 32'd0);
    chk("reset order_err", 32'(order_err), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drv(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d inst_addr_ok", i), 32'(inst_sram_addr_ok), 32'(vecs[i].e_iaok));
      chk($sformatf("v%0d data_addr_ok", i), 32'(data_sram_addr_ok), 32'(vecs[i].e_daok));
      chk($sformatf("v%0d inst_data_ok", i), 32'(inst_sram_data_ok), 32'(vecs[i].e_idok));
      chk($sformatf("v%0d data_data_ok", i), 32'(data_sram_data_ok), 32'(vecs[i].e_ddok));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d inst_rdata", i), inst_sram_rdata, vecs[i].e_irdata);
      chk($sformatf("v%0d data_rdata", i), data_sram_rdata, vecs[i].e_drdata);
      chk($sformatf("v%0d ot_count", i), 32'(ot_count), 32'(vecs[i].e_cnt));
    end

    // Fill to OT_DEPTH, request masked while full even with a same-cycle pop.
    for (int k = 0; k < 4; k++) begin
      drv(0,1,1,0,32'h0);
      chk($sformatf("fill%0d data_addr_ok", k), 32'(data_sram_addr_ok), 32'd1);
    end
    drv(0,1,1,0,32'h0);
    chk("full ot_count", 32'(ot_count), 32'd4);
    chk("full mem_req", 32'(mem_req), 32'd0);
    chk("full data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    drv(0,1,1,1,32'h55);
    chk("full+pop mem_req", 32'(mem_req), 32'd0);
    chk("full+pop data_data_ok", 32'(data_sram_data_ok), 32'd1);
    drv(0,1,1,0,32'h0);
    chk("after pop ot_count", 32'(ot_count), 32'd3);
    chk("after pop mem_req", 32'(mem_req), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drv(0,0,0,1,32'h60 + 32'(k));
      chk($sformatf("drain%0d data_data_ok", k), 32'(data_sram_data_ok), 32'd1);
    end
    drv(0,0,0,0,32'h0);
    chk("drained ot_count", 32'(ot_count), 32'd0);

    // Interleaved I, D, I with in-order responses.
    drv(1,0,1,0,32'h0); chk("il I0 addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    drv(0,1,1,0,32'h0); chk("il D1 addr_ok", 32'(data_sram_addr_ok), 32'd1);
    drv(1,0,1,0,32'h0); chk("il I2 addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    drv(0,0,0,1,32'd1);
    chk("il ot_count", 32'(ot_count), 32'd3);
    chk("il r1 inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("il r1 inst_rdata", inst_sram_rdata, 32'd1);
    chk("il r1 data_data_ok", 32'(data_sram_data_ok), 32'd0);
    drv(0,0,0,1,32'd2);
    chk("il r2 data_data_ok", 32'(data_sram_data_ok), 32'd1);
    chk("il r2 data_rdata", data_sram_rdata, 32'd2);
    chk("il r2 inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    drv(0,0,0,1,32'd3);
    chk("il r3 inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("il r3 inst_rdata", inst_sram_rdata, 32'd3);
    drv(0,0,0,0,32'h0);
    chk("il ot_count end", 32'(ot_count), 32'd0);

    // Simultaneous push and pop at ot_count = 2.
    drv(1,0,1,0,32'h0);
    drv(0,1,1,0,32'h0);
    drv(1,0,1,1,32'h77);
    chk("pp ot_count before", 32'(ot_count), 32'd2);
    chk("pp inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    chk("pp inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
    drv(0,0,0,0,32'h0);
    chk("pp ot_count after", 32'(ot_count), 32'd2);
    drv(0,0,0,1,32'h78);
    chk("pp head D data_data_ok", 32'(data_sram_data_ok), 32'd1);
    drv(0,0,0,1,32'h79);
    chk("pp head I inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("pp head I inst_rdata", inst_sram_rdata, 32'h79);
    drv(0,0,0,0,32'h0);
    chk("pp ot_count end", 32'(ot_count), 32'd0);

    // Response with nothing outstanding, then async reset mid-burst.
    drv(0,0,0,1,32'h99);
    chk("empty inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("empty data_data_ok", 32'(data_sram_data_ok), 32'd0);
    drv(0,0,0,0,32'h0);
    chk("order_err set", 32'(order_err), 32'd1);
    chk("empty ot_count", 32'(ot_count), 32'd0);
    drv(0,0,0,0,32'h0);
    chk("order_err sticky", 32'(order_err), 32'd1);
    repeat (3) drv(0,1,1,0,32'h0);
    drv(0,0,0,0,32'h0);
    chk("burst ot_count", 32'(ot_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("async rst ot_count", 32'(ot_count), 32'd0);
    chk("async rst order_err", 32'(order_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drv(0,0,0,0,32'h0);
    chk("post rst ot_count", 32'(ot_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one like-SRAM master port (toward the AXI bridge) between the instruction-fetch port and the data-memory port of the pipeline.
- The data port is the one driven by EX and consumed by MEM through data_sram_data_ok/rdata.
- Fixed priority with anti-starvation; an in-order tag FIFO routes each data_ok/rdata back to the port that issued the request.
- Sits between the pipeline's inst/data SRAM ports and the bridge.

Parameters:
- OT_DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, >=2)
- STARVE_MAX, 3, consecutive data grants allowed while inst is waiting before inst is forced

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_sram_req  in  1  inst request
- inst_sram_wr  in  1  write (always 0 in practice; passed through)
- inst_sram_size  in  2  0=byte 1=half 2=word
- inst_sram_wstrb  in  4  byte strobes
- inst_sram_addr  in  32  address
- inst_sram_wdata  in  32  write data
- inst_sram_addr_ok  out  1  request accepted
- inst_sram_data_ok  out  1  response for inst
- inst_sram_rdata  out  32  read data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data-port request, same meaning as the inst port
- data_sram_addr_ok/data_ok/rdata  out  1/1/32  data-port handshake and read data
- mem_req  out  1  shared request
- mem_wr/size/wstrb/addr/wdata  out  1/2/4/32/32  muxed request fields
- mem_addr_ok  in  1  bridge accepts request
- mem_data_ok  in  1  bridge response, returned in issue order
- mem_rdata  in  32  bridge read data
- ot_count  out  $clog2(OT_DEPTH)+1  current outstanding count
- order_err  out  1  sticky: data_ok received with nothing outstanding

Behaviour:
- Reset (async, active-high): FIFO rd/wr pointers = 0, ot_count = 0, starve counter = 0, order_err = 0. All combinational outputs are 0 while no req is present.
- Grant (combinational, same cycle):
  - sel_inst = inst_req & (~data_req | starve_cnt == STARVE_MAX).
  - Otherwise data wins if data_req.
- mem_req = (inst_req | data_req) & ~full. Request fields are muxed by the grant.
- full = (ot_count == OT_DEPTH). The request is masked when full even if a pop occurs in the same cycle; no full-bypass.
- addr_ok routing:
  - x_sram_addr_ok = mem_addr_ok & mem_req & granted==x.
  - The non-granted port sees addr_ok = 0 and must hold its request; requesters keep req/fields stable until addr_ok.
- Push: on mem_req & mem_addr_ok, write tag (0 = inst, 1 = data) at wr_ptr; wr_ptr++ modulo OT_DEPTH.
- Pop: on mem_data_ok & ~empty:
  - The head tag selects the target; that port gets data_ok = 1 and rdata = mem_rdata (same cycle, combinational). The other port gets data_ok = 0.
  - rd_ptr++ modulo OT_DEPTH.
- ot_count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- mem_data_ok while empty: no port is signalled, pointers are unchanged, order_err is set to 1 and held until reset.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each accepted data grant while inst_req = 1.
  - Clears on an accepted inst grant, or when inst_req = 0.
- Writes: a write also consumes an ordering slot; the bridge returns data_ok for writes, and data_ok is routed by tag like a read.
- Reset mid-operation: all outstanding tags are dropped. The bridge and the pipeline are reset by the same signal, so no late data_ok is expected; if one arrives, it is handled as the empty case above.
- No exception-flush input. The pipeline discards unwanted responses itself, so every accepted request receives exactly one data_ok.

Decomposition:
- Shared package/header: source tag encoding (SRC_INST = 0, SRC_DATA = 1), size encodings, and the OT_DEPTH default macro alongside the existing width header.
- One natural sub-module: ot_tag_fifo.
  - 1-bit wide, OT_DEPTH deep.
  - push/pop/full/empty/count/head outputs, with the async-reset pointers.

Test Plan:
- Only data_req, addr 0x1000_0004, read, mem_addr_ok = 1 → data_addr_ok = 1 same cycle. mem_data_ok 2 cycles later with rdata 0xDEADBEEF → data_data_ok = 1 and data_rdata = 0xDEADBEEF; inst_data_ok stays 0; ot_count goes 1 → 0.
- inst_req and data_req both held, addr_ok always 1, STARVE_MAX = 3 → grants D, D, D, I, D, D, D, I.
- Issue 4 requests with data_ok withheld → ot_count = 4 and mem_req = 0 with req still asserted. One data_ok returned → mem_req reasserts the next cycle.
- Interleaved order I, D, I, then 3 data_ok pulses with rdata 1, 2, 3 → inst gets 1, data gets 2, inst gets 3.
- Same-cycle push and pop at ot_count = 2 → ot_count stays 2; tags are preserved in order.
- mem_data_ok with ot_count = 0 → no port data_ok, order_err = 1 and sticky. Assert reset mid-burst with ot_count = 3 → ot_count = 0 and order_err = 0 immediately (asynchronous).
